// File: rtl/spi_master_trx_chan.sv
// SPI master character transceiver: one 1..CHAR_NBITS-bit character per
// valid/ready request, all four CPOL/CPHA modes, MSB/LSB first, NUM_CS chip
// selects with optional hold across characters, loopback and TX-only mode.
module spi_master_trx_chan #(
   parameter int CHAR_NBITS = 32,
   parameter int DIV_WIDTH  = 8,
   parameter int NUM_CS     = 4,
   parameter int LEN_W      = $clog2(CHAR_NBITS),
   parameter int CS_IDX_W   = $clog2(NUM_CS)
) (
   input  logic                  S_SYSCLK,
   input  logic                  S_RESET,
   input  logic                  S_ENABLE,
   input  logic                  S_CPOL,
   input  logic                  S_CPHA,
   input  logic                  S_REV,
   input  logic                  S_TX_ONLY,
   input  logic                  S_LOOP,
   input  logic [LEN_W-1:0]      S_CHAR_LEN,
   input  logic [DIV_WIDTH-1:0]  S_NDIVIDER,
   input  logic [CS_IDX_W-1:0]   S_CS_SEL,
   input  logic                  S_CS_HOLD,
   input  logic                  S_CHAR_VALID,
   output logic                  S_CHAR_READY,
   input  logic [CHAR_NBITS-1:0] S_WCHAR,
   output logic [CHAR_NBITS-1:0] S_RCHAR,
   output logic                  S_RCHAR_VALID,
   output logic                  S_BUSY,
   output logic                  S_SPI_SCK,
   output logic                  S_SPI_MOSI,
   input  logic                  S_SPI_MISO,
   output logic [NUM_CS-1:0]     S_SPI_CS_N
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(CHAR_NBITS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;
   state_t state_q, state_d;

   logic                  cpol_q, cpha_q, rev_q, tx_only_q, loop_q, hold_q;
   logic [LEN_W-1:0]      len_q;
   logic [DIV_WIDTH-1:0]  ndiv_q, cnt_q;
   logic [LEN_W:0]        edge_q;
   logic [NUM_CS-1:0]     cs_n_q;
   logic                  sck_q, mosi_q;
   logic [CHAR_NBITS-1:0] tx_sr, rx_sr, rchar_q, rx_final, tx_load;
   logic                  accept, tick, last_edge, sample_en, drive_en;
   logic                  rx_strobe, rx_bit, tx_first, tx_next, ready, busy;

   // One-hot active-low select; an out-of-range index selects nothing.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_IDX_W-1:0] sel);
      logic [NUM_CS-1:0] r;
      r = '1;
      if (int'(sel) < NUM_CS) r[sel] = 1'b0;
      return r;
   endfunction

   assign tick      = (cnt_q == '0);
   assign last_edge = (edge_q == {len_q, 1'b1});
   // Even edge index is the leading SCK edge, odd is the trailing edge.
   assign sample_en = cpha_q ? edge_q[0] : ~edge_q[0];
   assign drive_en  = cpha_q ? ~edge_q[0] : (edge_q[0] & ~last_edge);
   assign rx_bit    = loop_q ? mosi_q : S_SPI_MISO;
   // MSB-first characters are left-justified so the outgoing bit is always the top bit.
   assign tx_load   = S_REV ? (S_WCHAR << (LEN_MAX - S_CHAR_LEN)) : S_WCHAR;
   assign tx_first  = S_REV ? tx_load[CHAR_NBITS-1] : tx_load[0];
   assign tx_next   = rev_q ? tx_sr[CHAR_NBITS-1] : tx_sr[0];
   // LSB-first bits enter at the top, so right-justify them at the end.
   assign rx_final  = rev_q ? rx_sr : (rx_sr >> (LEN_MAX - len_q));
   assign accept    = (state_q == ST_IDLE) && S_CHAR_VALID && S_ENABLE && !S_RESET;
   assign rx_strobe = (state_q == ST_HOLD) && tick && S_ENABLE && !tx_only_q;

   // State register.
   always_ff @(posedge S_SYSCLK) begin
      if (S_RESET) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state and handshake decode; disable aborts from any active state.
   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      busy    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready = S_ENABLE && !S_RESET;
            if (accept) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            busy = 1'b1;
            if (tick) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (tick && last_edge) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            busy = 1'b1;
            if (tick) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_q != ST_IDLE && !S_ENABLE) state_d = ST_IDLE;
   end

   // Control: config latch, divider, edge counter, SCK/MOSI/CS and received character.
   always_ff @(posedge S_SYSCLK) begin
      if (S_RESET) begin
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         rev_q     <= 1'b0;
         tx_only_q <= 1'b0;
         loop_q    <= 1'b0;
         hold_q    <= 1'b0;
         len_q     <= '0;
         ndiv_q    <= '0;
         cnt_q     <= '0;
         edge_q    <= '0;
         cs_n_q    <= '1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b1;
         rchar_q   <= '0;
      end else if (state_q == ST_IDLE) begin
         if (accept) begin
            cpol_q    <= S_CPOL;
            cpha_q    <= S_CPHA;
            rev_q     <= S_REV;
            tx_only_q <= S_TX_ONLY;
            loop_q    <= S_LOOP;
            hold_q    <= S_CS_HOLD;
            len_q     <= S_CHAR_LEN;
            ndiv_q    <= S_NDIVIDER;
            cnt_q     <= S_NDIVIDER;
            edge_q    <= '0;
            sck_q     <= S_CPOL;
            cs_n_q    <= cs_decode(S_CS_SEL);
            mosi_q    <= S_CPHA ? 1'b1 : tx_first;
         end else begin
            cnt_q <= '0;
            if (!S_ENABLE) cs_n_q <= '1;
         end
      end else if (!S_ENABLE) begin
         cnt_q  <= '0;
         cs_n_q <= '1;
         sck_q  <= cpol_q;
         mosi_q <= 1'b1;
      end else begin
         cnt_q <= tick ? ndiv_q : cnt_q - DIV_WIDTH'(1);
         if (state_q == ST_SHIFT && tick) begin
            sck_q  <= ~sck_q;
            edge_q <= edge_q + (LEN_W+1)'(1);
            if (drive_en) mosi_q <= tx_next;
         end
         if (state_q == ST_HOLD && tick) begin
            mosi_q <= 1'b1;
            if (!hold_q)   cs_n_q  <= '1;
            if (rx_strobe) rchar_q <= rx_final;
         end
      end
   end

   // Transmit and receive shift registers.
   always_ff @(posedge S_SYSCLK) begin
      if (accept) begin
         rx_sr <= '0;
         tx_sr <= S_CPHA ? tx_load : (S_REV ? (tx_load << 1) : (tx_load >> 1));
      end else if (state_q == ST_SHIFT && tick) begin
         if (sample_en) rx_sr <= rev_q ? {rx_sr[CHAR_NBITS-2:0], rx_bit}
                                       : {rx_bit, rx_sr[CHAR_NBITS-1:1]};
         if (drive_en)  tx_sr <= rev_q ? (tx_sr << 1) : (tx_sr >> 1);
      end
   end

   assign S_CHAR_READY  = ready;
   assign S_BUSY        = busy;
   assign S_RCHAR_VALID = rx_strobe;
   assign S_RCHAR       = rx_strobe ? rx_final : rchar_q;
   assign S_SPI_SCK     = (state_q == ST_IDLE) ? S_CPOL : (loop_q ? cpol_q : sck_q);
   assign S_SPI_MOSI    = (state_q == ST_IDLE || loop_q) ? 1'b1 : mosi_q;
   assign S_SPI_CS_N    = loop_q ? '1 : cs_n_q;

endmodule

// File: tb/tb_spi_master_trx_chan.sv
// Directed bench for spi_master_trx_chan: modes, bit order, loopback,
// chip-select bursts, abort, reset and TX-only behaviour.
module tb_spi_master_trx_chan;

   logic        clk = 1'b0;
   logic        S_RESET, S_ENABLE, S_CPOL, S_CPHA, S_REV, S_TX_ONLY, S_LOOP;
   logic [4:0]  S_CHAR_LEN;
   logic [7:0]  S_NDIVIDER;
   logic [1:0]  S_CS_SEL;
   logic        S_CS_HOLD, S_CHAR_VALID, S_CHAR_READY;
   logic [31:0] S_WCHAR, S_RCHAR;
   logic        S_RCHAR_VALID, S_BUSY, S_SPI_SCK, S_SPI_MOSI, S_SPI_MISO;
   logic [3:0]  S_SPI_CS_N;

   int          checks = 0;
   int          errors = 0;
   int          busy_cyc, sck_pulses, vld_cnt, pin_moves, edges;
   logic [31:0] mosi_cap, rchar_cap;
   logic [3:0]  cs_first;
   logic        cs_changed, prev;

   always #5 clk = ~clk;

   spi_master_trx_chan dut (
      .S_SYSCLK(clk), .S_RESET(S_RESET), .S_ENABLE(S_ENABLE), .S_CPOL(S_CPOL),
      .S_CPHA(S_CPHA), .S_REV(S_REV), .S_TX_ONLY(S_TX_ONLY), .S_LOOP(S_LOOP),
      .S_CHAR_LEN(S_CHAR_LEN), .S_NDIVIDER(S_NDIVIDER), .S_CS_SEL(S_CS_SEL),
      .S_CS_HOLD(S_CS_HOLD), .S_CHAR_VALID(S_CHAR_VALID), .S_CHAR_READY(S_CHAR_READY),
      .S_WCHAR(S_WCHAR), .S_RCHAR(S_RCHAR), .S_RCHAR_VALID(S_RCHAR_VALID),
      .S_BUSY(S_BUSY), .S_SPI_SCK(S_SPI_SCK), .S_SPI_MOSI(S_SPI_MOSI),
      .S_SPI_MISO(S_SPI_MISO), .S_SPI_CS_N(S_SPI_CS_N)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   function automatic logic slave_bit(input logic [31:0] d, input int nbits, input int idx);
      if (idx >= nbits) return 1'b0;
      return S_REV ? d[nbits-1-idx] : d[idx];
   endfunction

   // Issue one character from a falling edge, act as the SPI slave, and
   // record pin activity until BUSY drops (bounded). Returns on the first idle falling edge.
   task automatic run_xfer(input logic [31:0] w, input logic [31:0] sdata);
      int nbits, idx;
      logic psck;
      nbits = int'(S_CHAR_LEN) + 1;
      idx = 0;
      busy_cyc = 0; sck_pulses = 0; vld_cnt = 0; pin_moves = 0;
      mosi_cap = '0; rchar_cap = '0; cs_changed = 1'b0;
      S_SPI_MISO = slave_bit(sdata, nbits, 0);
      S_WCHAR = w;
      S_CHAR_VALID = 1'b1;
      psck = S_SPI_SCK;
      @(posedge clk);
      @(negedge clk);
      S_CHAR_VALID = 1'b0;
      cs_first = S_SPI_CS_N;
      for (int c = 0; c < 400; c++) begin
         if (!S_BUSY) break;
         busy_cyc++;
         if (S_SPI_CS_N !== cs_first) cs_changed = 1'b1;
         if (S_RCHAR_VALID) begin vld_cnt++; rchar_cap = S_RCHAR; end
         if (S_SPI_SCK !== S_CPOL || S_SPI_MOSI !== 1'b1 || S_SPI_CS_N !== 4'hF) pin_moves++;
         if (S_SPI_SCK !== psck) begin
            if (S_SPI_SCK !== S_CPOL) begin
               sck_pulses++;
               if (!S_CPHA) mosi_cap = {mosi_cap[30:0], S_SPI_MOSI};
               else begin S_SPI_MISO = slave_bit(sdata, nbits, idx); idx++; end
            end else begin
               if (S_CPHA) mosi_cap = {mosi_cap[30:0], S_SPI_MOSI};
               else begin idx++; S_SPI_MISO = slave_bit(sdata, nbits, idx); end
            end
         end
         psck = S_SPI_SCK;
         @(negedge clk);
      end
   endtask

   initial begin
      S_RESET = 1'b1; S_ENABLE = 1'b0; S_CPOL = 1'b1; S_CPHA = 1'b0; S_REV = 1'b1;
      S_TX_ONLY = 1'b0; S_LOOP = 1'b0; S_CHAR_LEN = 5'd7; S_NDIVIDER = 8'd1;
      S_CS_SEL = 2'd0; S_CS_HOLD = 1'b0; S_CHAR_VALID = 1'b0; S_WCHAR = '0;
      S_SPI_MISO = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", S_CHAR_READY, 0);
      check("rst_busy", S_BUSY, 0);
      check("rst_rvalid", S_RCHAR_VALID, 0);
      check("rst_rchar", S_RCHAR, 0);
      check("rst_cs", S_SPI_CS_N, 4'hF);
      check("rst_mosi", S_SPI_MOSI, 1);
      check("rst_sck_cpol1", S_SPI_SCK, 1);
      S_RESET = 1'b0; S_ENABLE = 1'b1; S_CPOL = 1'b0;
      @(negedge clk);
      check("idle_ready", S_CHAR_READY, 1);
      check("idle_sck_cpol0", S_SPI_SCK, 0);

      // Mode 0, MSB first, 8 bits, N=1
      run_xfer(32'hA5, 32'h3C);
      check("m0_mosi", mosi_cap, 32'hA5);
      check("m0_sck", sck_pulses, 8);
      check("m0_rchar", rchar_cap, 32'h3C);
      check("m0_rvalid_cnt", vld_cnt, 1);
      check("m0_busy", busy_cyc, 36);
      check("m0_cs_low", cs_first, 4'b1110);
      check("m0_rchar_held", S_RCHAR, 32'h3C);

      // Mode 3, LSB first, 16 bits, loopback
      S_CPOL = 1'b1; S_CPHA = 1'b1; S_REV = 1'b0; S_CHAR_LEN = 5'd15; S_LOOP = 1'b1;
      run_xfer(32'h1234, 32'h0);
      check("lb_rchar", rchar_cap, 32'h1234);
      check("lb_pins_idle", pin_moves, 0);
      check("lb_sck", sck_pulses, 0);
      check("lb_busy", busy_cyc, 68);

      // Mode 1, MSB first, 32 bits, N=0, CS 2
      S_LOOP = 1'b0; S_CPOL = 1'b0; S_CPHA = 1'b1; S_REV = 1'b1;
      S_CHAR_LEN = 5'd31; S_NDIVIDER = 8'd0; S_CS_SEL = 2'd2;
      run_xfer(32'h13579BDF, 32'hDEADBEEF);
      check("m1_cs", cs_first, 4'b1011);
      check("m1_cs_stable", cs_changed, 0);
      check("m1_sck", sck_pulses, 32);
      check("m1_busy", busy_cyc, 66);
      check("m1_mosi", mosi_cap, 32'h13579BDF);
      check("m1_rchar", rchar_cap, 32'hDEADBEEF);
      check("m1_cs_release", S_SPI_CS_N, 4'hF);

      // Burst with CS hold on CS 0, mode 0
      S_CPHA = 1'b0; S_CHAR_LEN = 5'd7; S_NDIVIDER = 8'd1; S_CS_SEL = 2'd0; S_CS_HOLD = 1'b1;
      run_xfer(32'h11, 32'hC3);
      check("burst1_cs_stable", cs_changed, 0);
      check("burst1_rchar", rchar_cap, 32'hC3);
      check("burst_gap_cs", S_SPI_CS_N, 4'b1110);
      check("burst_gap_ready", S_CHAR_READY, 1);
      S_CS_HOLD = 1'b0;
      run_xfer(32'h22, 32'h5A);
      check("burst2_cs", cs_first, 4'b1110);
      check("burst2_cs_stable", cs_changed, 0);
      check("burst2_mosi", mosi_cap, 32'h22);
      check("burst_end_cs", S_SPI_CS_N, 4'hF);

      // Abort by disable after 3 SCK edges
      S_WCHAR = 32'hF0; S_CHAR_VALID = 1'b1;
      @(posedge clk);
      @(negedge clk);
      S_CHAR_VALID = 1'b0;
      edges = 0; prev = S_SPI_SCK;
      for (int c = 0; c < 100 && edges < 3; c++) begin
         @(negedge clk);
         if (S_SPI_SCK !== prev) edges++;
         prev = S_SPI_SCK;
      end
      check("abort_edges_seen", edges, 3);
      S_ENABLE = 1'b0;
      @(negedge clk);
      check("abort_cs", S_SPI_CS_N, 4'hF);
      check("abort_sck", S_SPI_SCK, 0);
      check("abort_mosi", S_SPI_MOSI, 1);
      check("abort_busy", S_BUSY, 0);
      check("abort_rvalid", S_RCHAR_VALID, 0);
      check("abort_rchar", S_RCHAR, 32'h5A);
      S_ENABLE = 1'b1;
      @(negedge clk);

      // Same abort point, by reset
      S_CHAR_VALID = 1'b1;
      @(posedge clk);
      @(negedge clk);
      S_CHAR_VALID = 1'b0;
      edges = 0; prev = S_SPI_SCK;
      for (int c = 0; c < 100 && edges < 3; c++) begin
         @(negedge clk);
         if (S_SPI_SCK !== prev) edges++;
         prev = S_SPI_SCK;
      end
      check("rstabort_edges_seen", edges, 3);
      S_RESET = 1'b1;
      @(negedge clk);
      check("rstabort_rchar", S_RCHAR, 0);
      check("rstabort_cs", S_SPI_CS_N, 4'hF);
      check("rstabort_busy", S_BUSY, 0);
      check("rstabort_ready", S_CHAR_READY, 0);
      S_RESET = 1'b0;
      @(negedge clk);

      // LSB first, mode 0, slave returns 0x77
      S_REV = 1'b0;
      run_xfer(32'h01, 32'h77);
      check("lsb_rchar", rchar_cap, 32'h77);
      check("lsb_mosi_reversed", mosi_cap, 32'h80);

      // TX only: RCHAR untouched, no strobe
      S_REV = 1'b1; S_TX_ONLY = 1'b1;
      run_xfer(32'hFF, 32'h00);
      check("txo_mosi", mosi_cap, 32'hFF);
      check("txo_rvalid_cnt", vld_cnt, 0);
      check("txo_rchar", S_RCHAR, 32'h77);
      check("txo_busy", busy_cyc, 36);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master_trx_chan.md
# spi_master_trx_chan

Parametrised SPI master character transceiver that shifts one character of 1..CHAR_NBITS bits per request in any of the four CPOL/CPHA modes, MSB- or LSB-first. It adds NUM_CS chip selects with optional CS hold across characters for bursts, a valid/ready request handshake, a one-cycle receive strobe, clean abort, internal loopback and TX-only mode. It sits between the SPI register/FIFO front end and the pads, runs entirely on S_SYSCLK, and replaces the edge-triggered character engine.

## Interface
- CHAR_NBITS, 32, maximum character width; also the width of S_WCHAR and S_RCHAR
- DIV_WIDTH, 8, divider width
- NUM_CS, 4, number of chip-select outputs
- LEN_W, $clog2(CHAR_NBITS), width of S_CHAR_LEN
- CS_IDX_W, $clog2(NUM_CS), width of S_CS_SEL

Ports:
- S_SYSCLK  in  1  platform clock; the only clock
- S_RESET  in  1  synchronous, active-high reset
- S_ENABLE  in  1  block enable; low aborts any transfer
- S_CPOL, S_CPHA  in  1 each  SPI mode
- S_REV  in  1  1 = MSB first, 0 = LSB first
- S_TX_ONLY  in  1  ignore MISO, no receive strobe
- S_LOOP  in  1  internal loopback: MOSI feeds the receiver and the pins stay idle
- S_CHAR_LEN  in  LEN_W  character length = S_CHAR_LEN+1 bits
- S_NDIVIDER  in  DIV_WIDTH  SCK half-period = S_NDIVIDER+1 sysclks
- S_CS_SEL  in  CS_IDX_W  chip select index
- S_CS_HOLD  in  1  keep CS asserted after this character
- S_CHAR_VALID  in  1  character request
- S_CHAR_READY  out  1  request accepted when VALID&READY
- S_WCHAR  in  CHAR_NBITS  transmit character, right-justified
- S_RCHAR  out  CHAR_NBITS  received character, right-justified, upper bits 0
- S_RCHAR_VALID  out  1  one-cycle strobe, S_RCHAR updated
- S_BUSY  out  1  transfer in progress
- S_SPI_SCK  out  1
- S_SPI_MOSI  out  1
- S_SPI_MISO  in  1
- S_SPI_CS_N  out  NUM_CS  active-low chip selects

## Operation
- On accept, latch all mode/config inputs, S_WCHAR, S_CS_SEL and S_CS_HOLD. Input changes during a transfer are ignored.
- Half-period tick: counter reloads S_NDIVIDER at each tick; one tick every N+1 cycles.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
  - IDLE: READY = S_ENABLE, BUSY = 0.
  - SETUP: selected CS_N low for 1 half-period. With CPHA=0 the first bit is on MOSI during SETUP.
  - SHIFT: 2*bits half-periods; SCK toggles at each tick.
    - CPHA=0: sample on leading edge, drive next bit on trailing edge.
    - CPHA=1: drive on leading edge, sample on trailing edge.
  - HOLD: SCK = CPOL for 1 half-period. Then CS_N goes all 1 unless the latched CS_HOLD is set, in which case the selected CS stays low through IDLE until the next accept or the next disable/reset.
- Bit order:
  - MSB-first transmits bit bits-1 down to 0 and receives by shifting left into bit 0.
  - LSB-first transmits bit 0 upward and places received bits at bits-1 downward.
  - In both cases the result is right-justified.
- S_LOOP=1: receiver samples the internal MOSI. Pins SCK=CPOL, MOSI=1, CS_N all 1.
- S_TX_ONLY=1: MISO ignored, S_RCHAR unchanged, no S_RCHAR_VALID.
- S_CS_SEL >= NUM_CS: no CS asserted, but the transfer still runs.
- Idle pins: SCK = live S_CPOL, MOSI = 1.
- Abort (S_ENABLE=0 in any non-IDLE state): the next cycle is IDLE with CS_N all 1, SCK=CPOL, MOSI=1. No S_RCHAR_VALID; S_RCHAR is held.

## Timing
- Reset values:
  - S_CHAR_READY=0, S_BUSY=0, S_RCHAR_VALID=0, S_RCHAR=0
  - S_SPI_CS_N all 1, S_SPI_MOSI=1, S_SPI_SCK=S_CPOL
  - FSM IDLE, divider counter 0
- Accept at cycle t0 -> BUSY=1 and CS asserted from t0+1.
- Cycles busy: (N+1)*(2*bits+2).
- S_RCHAR_VALID pulses in the last HOLD cycle, and S_RCHAR is valid from the same cycle. READY returns in the following cycle.
- READY is low from t0+1 until IDLE; back-to-back characters therefore have 1 idle cycle between them.
- S_RESET mid-transfer forces the reset values on the next edge, overriding everything including S_ENABLE.

## Test plan
- Mode 0, MSB first, LEN=7, N=1, WCHAR=0xA5, slave returns 0x3C:
  - MOSI sequence 1,0,1,0,0,1,0,1 and 8 SCK pulses
  - RCHAR=0x0000003C, RCHAR_VALID one cycle, BUSY 36 cycles
- Mode 3, LSB first, LEN=15, LOOP=1, WCHAR=0x1234:
  - RCHAR=0x00001234
  - SCK=1, MOSI=1 and CS_N=4'b1111 throughout
- Mode 1, LEN=31, N=0, CS_SEL=2:
  - CS_N=4'b1011 while BUSY
  - 32 SCK pulses, BUSY 66 cycles
- Burst: 0x11 with CS_HOLD=1, then 0x22 with CS_HOLD=0, CS_SEL=0:
  - CS_N[0] stays low continuously from the first SETUP to the end of the second HOLD, then returns to 1.
- S_ENABLE dropped after 3 SCK edges, previous RCHAR=0x5A:
  - Next cycle: CS_N=1111, SCK=CPOL, no RCHAR_VALID, RCHAR=0x5A
  - Repeating with S_RESET instead gives RCHAR=0.
- TX_ONLY=1, LEN=7, WCHAR=0xFF, MISO=0:
  - MOSI is all 1 for 8 bits
  - No RCHAR_VALID; RCHAR is unchanged.
